// File: rtl/cpc_multirom_pkg.sv
// Shared constants, key FSM states and helpers for the CPC multi-ROM controller.
// The key FSM state type is only used when CPC_MULTIROM_PROG_EN is defined.
package cpc_multirom_pkg;

  localparam logic [7:0] KEY1_VAL = 8'hA5;
  localparam logic [7:0] KEY2_VAL = 8'h5A;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY1     = 2'd1,
    UNLOCKED = 2'd2,
    RECOVER  = 2'd3
  } key_state_e;

  // Bit positions within A15..A8
  localparam int UPPER_A15_BIT   = 7;
  localparam int UPPER_A14_BIT   = 6;
  localparam int SELPORT_A13_BIT = 5;
  localparam logic SELPORT_A13_VAL = 1'b0;

  // Strobe order in the synchroniser vector
  localparam int STB_IOREQ = 0;
  localparam int STB_MREQ  = 1;
  localparam int STB_WR    = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int clog2_min1(input int value);
    return (clog2(value) > 0) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/cpc_multirom_ctrl_bus_sync.sv
// Multi-stage synchroniser for the active-low CPC bus strobes with edge detects.
// Flops reset to 0 (asserted) so a strobe already low when reset lifts is not seen as a new edge.
module cpc_bus_sync #(
  parameter int STAGES = 2,
  parameter int W      = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] fall_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign sync_o = stage_q[STAGES-1];
  assign fall_o = prev_q & ~sync_o;
  assign rise_o = ~prev_q & sync_o;

endmodule

// File: rtl/cpc_multirom_ctrl.sv
// N-socket CPC upper-ROM controller: &DFxx ROM-select latch, bank/socket decode, ROMDIS.
// Optional EEPROM write path with key unlock and recovery lockout under CPC_MULTIROM_PROG_EN.
module cpc_multirom_ctrl
  import cpc_multirom_pkg::*;
#(
  parameter int         NUM_SKT       = 2,
  parameter int         BANKS_PER_SKT = 2,
  parameter int         ROM_BASE      = 0,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] PROG_PORT     = 8'hFE,
  parameter int         WR_RECOVER    = 40000,
  localparam int        NBANK         = NUM_SKT * BANKS_PER_SKT,
  localparam int        RAW           = clog2_min1(BANKS_PER_SKT)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [7:0]           A_HI,
  input  logic [7:0]           D,
  input  logic                 MREQ_B,
  input  logic                 IOREQ_B,
  input  logic                 RD_B,
  input  logic                 WR_B,
  input  logic                 ROMEN_B,
  input  logic [NBANK-1:0]     dip,
  output logic [NUM_SKT-1:0]   rom_cs_b,
  output logic [RAW-1:0]       roma_hi,
  output logic                 romoe_b,
  output logic                 romdis,
  output logic [NUM_SKT-1:0]   rom_we_b,
  output logic [7:0]           rom_sel,
  output logic                 prog_busy
);

  localparam int IDXW = clog2_min1(NBANK);
  localparam int SW   = clog2_min1(NUM_SKT);
  localparam int BSH  = clog2(BANKS_PER_SKT);
  localparam logic [RAW-1:0] RAW_MASK = RAW'(BANKS_PER_SKT - 1);

  logic [2:0] stb_sync, stb_fall, stb_rise;

  cpc_bus_sync #(.STAGES(SYNC_STAGES), .W(3)) u_sync (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .async_i ({WR_B, MREQ_B, IOREQ_B}),
    .sync_o  (stb_sync),
    .fall_o  (stb_fall),
    .rise_o  (stb_rise)
  );

  // Both strobes must fall together: one capture per I/O write cycle
  logic io_wr_evt, sel_wr;
  assign io_wr_evt = stb_fall[STB_IOREQ] & stb_fall[STB_WR];
  assign sel_wr    = io_wr_evt & (A_HI[SELPORT_A13_BIT] == SELPORT_A13_VAL);

  logic [7:0]     rom_sel_q, rom_sel_d;
  logic           hit_q, hit_d;
  logic [SW-1:0]  socket_q, socket_d;
  logic [RAW-1:0] roma_q, roma_d;
  logic [8:0]     idx9;
  logic           in_range;

  always_comb begin
    rom_sel_d = sel_wr ? D : rom_sel_q;
    idx9      = {1'b0, rom_sel_q} - 9'(ROM_BASE);
    in_range  = ~idx9[8] && (idx9 < 9'(NBANK));
    hit_d     = in_range & dip[idx9[IDXW-1:0]];
    socket_d  = SW'(idx9[7:0] >> BSH);
    roma_d    = idx9[RAW-1:0] & RAW_MASK;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rom_sel_q <= '0;
      hit_q     <= 1'b0;
      socket_q  <= '0;
      roma_q    <= '0;
    end else begin
      rom_sel_q <= rom_sel_d;
      hit_q     <= hit_d;
      socket_q  <= socket_d;
      roma_q    <= roma_d;
    end
  end

  logic upper, upper_addr;
  assign upper_addr = A_HI[UPPER_A15_BIT] & A_HI[UPPER_A14_BIT];
  assign upper      = ~ROMEN_B & upper_addr;

  always_comb begin
    rom_cs_b = '1;
    for (int i = 0; i < NUM_SKT; i++)
      rom_cs_b[i] = ~(hit_q & upper & (socket_q == SW'(i)));
  end

  assign romdis  = hit_q & upper;
  assign romoe_b = ~(hit_q & upper & ~RD_B);
  assign roma_hi = roma_q;
  assign rom_sel = rom_sel_q;

`ifdef CPC_MULTIROM_PROG_EN
  localparam int CW = clog2_min1(WR_RECOVER + 1);

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          lock_q, lock_d;
  logic          prog_wr, mem_wr_s;

  assign prog_wr  = io_wr_evt & (A_HI == PROG_PORT);
  assign mem_wr_s = ~stb_sync[STB_MREQ] & ~stb_sync[STB_WR] & hit_q & upper_addr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= LOCKED;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    lock_d  = 1'b0;
    unique case (state_q)
      LOCKED: if (prog_wr && D == KEY1_VAL) state_d = KEY1;
      KEY1:   if (prog_wr) state_d = (D == KEY2_VAL) ? UNLOCKED : LOCKED;
      UNLOCKED: begin
        pend_d = pend_q | mem_wr_s;
        if (prog_wr) begin
          state_d = LOCKED;
          pend_d  = 1'b0;
        end else if (pend_q && stb_rise[STB_WR]) begin
          state_d = RECOVER;
          cnt_d   = CW'(WR_RECOVER - 1);
          pend_d  = 1'b0;
        end
      end
      RECOVER: begin
        // A lock request during recovery is honoured once the lockout expires
        lock_d = lock_q | prog_wr;
        if (cnt_q == '0) begin
          state_d = (lock_q | prog_wr) ? LOCKED : UNLOCKED;
          lock_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_comb begin
    rom_we_b = '1;
    for (int i = 0; i < NUM_SKT; i++)
      rom_we_b[i] = ~((state_q == UNLOCKED) & hit_q & ~MREQ_B & ~WR_B & upper_addr
                      & (socket_q == SW'(i)));
  end

  assign prog_busy = (state_q == RECOVER);
`else
  logic unused_prog;
  assign unused_prog = ^{stb_sync, stb_rise, stb_fall[STB_MREQ]};
  assign rom_we_b  = '1;
  assign prog_busy = 1'b0;
`endif

endmodule

// File: tb/tb_cpc_multirom_ctrl.sv
// Scoreboard bench for cpc_multirom_ctrl (2 sockets x 2 banks, ROM_BASE 0).
// Write-path checks are included when CPC_MULTIROM_PROG_EN is defined.
module tb_cpc_multirom_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] A_HI, D;
  logic       MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B;
  logic [3:0] dip;
  logic [1:0] rom_cs_b, rom_we_b;
  logic [0:0] roma_hi;
  logic       romoe_b, romdis, prog_busy;
  logic [7:0] rom_sel;

  cpc_multirom_ctrl #(
    .NUM_SKT(2), .BANKS_PER_SKT(2), .ROM_BASE(0), .SYNC_STAGES(2),
    .PROG_PORT(8'hFE), .WR_RECOVER(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .A_HI(A_HI), .D(D),
    .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .ROMEN_B(ROMEN_B),
    .dip(dip), .rom_cs_b(rom_cs_b), .roma_hi(roma_hi), .romoe_b(romoe_b),
    .romdis(romdis), .rom_we_b(rom_we_b), .rom_sel(rom_sel), .prog_busy(prog_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] sel;
    logic [1:0] cs;
    logic       roma;
    logic       oe;
    logic       dis;
    logic [1:0] we;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  logic smp = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   busy_cycles = 0;

  // Monitor: compares the DUT outputs against the oldest expectation
  always @(negedge CLK) begin
    if (smp) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sample_without_expectation: got sel=%h", rom_sel);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rom_sel, rom_cs_b, roma_hi, romoe_b, romdis, rom_we_b, prog_busy} !==
            {e.sel, e.cs, e.roma, e.oe, e.dis, e.we, e.busy}) begin
          bad++;
          $display("FAIL %s: got sel=%h cs=%b roma=%b oe=%b dis=%b we=%b busy=%b, want sel=%h cs=%b roma=%b oe=%b dis=%b we=%b busy=%b",
                   e.name, rom_sel, rom_cs_b, roma_hi, romoe_b, romdis, rom_we_b, prog_busy,
                   e.sel, e.cs, e.roma, e.oe, e.dis, e.we, e.busy);
        end
      end
    end
  end

  always @(negedge CLK) if (prog_busy) busy_cycles++;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_now(input string n, input logic [7:0] sel, input logic [1:0] cs,
                            input logic roma, input logic oe, input logic dis,
                            input logic [1:0] we, input logic busy);
    sb.push_back('{n, sel, cs, roma, oe, dis, we, busy});
    smp = 1'b1;
    tick(1);
    smp = 1'b0;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: monitor timeout, %0d expectations left, want 0", n, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_int(input string n, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask

  task automatic idle();
    IOREQ_B = 1'b1; MREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; ROMEN_B = 1'b1;
    A_HI = 8'h00; D = 8'h00;
  endtask

  task automatic bus(input logic [7:0] a, input logic romen_b, input logic mreq_b,
                     input logic rd_b, input logic wr_b);
    A_HI = a; ROMEN_B = romen_b; MREQ_B = mreq_b; RD_B = rd_b; WR_B = wr_b; IOREQ_B = 1'b1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    A_HI = a; D = d; IOREQ_B = 1'b0; WR_B = 1'b0;
    tick(4);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    tick(3);
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(2);
  endtask

  initial begin
    idle();
    dip = 4'b1111;
    RESET = 1'b1;
    tick(3);
    RESET = 1'b0;
    tick(2);
    expect_now("reset_state", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);

    // Select latency: unchanged after 2 edges, captured on the 3rd
    A_HI = 8'hDF; D = 8'h01; IOREQ_B = 1'b0; WR_B = 1'b0;
    tick(2);
    expect_now("sel_before_latency", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_now("sel_at_latency", 8'h01, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    tick(3);

    bus(8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("rom01_read", 8'h01, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    bus(8'hC0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_now("rom01_no_rd", 8'h01, 2'b10, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
    bus(8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("rom01_a14_low", 8'h01, 2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    bus(8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_now("rom01_romen_high", 8'h01, 2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    idle();

    dip = 4'b0111;
    io_write(8'hDF, 8'h03);
    bus(8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("rom03_dip_off", 8'h03, 2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    idle();
    dip = 4'b1111;
    tick(2);
    bus(8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("rom03_dip_on", 8'h03, 2'b01, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    idle();

    io_write(8'hDF, 8'h07);
    bus(8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("rom07_out_of_range", 8'h07, 2'b11, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    idle();

    io_write(8'hDF, 8'h02);
    bus(8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("rom02_read", 8'h02, 2'b01, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    idle();

    io_write(8'hFF, 8'h01);
    bus(8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("a13_high_ignored", 8'h02, 2'b01, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    idle();

    io_write(8'hDF, 8'h02);
    bus(8'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("rom02_rewrite", 8'h02, 2'b01, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    idle();

    // Reset while the strobes are low; they stay low past reset release
    A_HI = 8'hDF; D = 8'h03; IOREQ_B = 1'b0; WR_B = 1'b0;
    tick(2);
    RESET = 1'b1;
    expect_now("in_reset", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    RESET = 1'b0;
    tick(3);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    tick(3);
    expect_now("reset_aborts_capture", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);

    bus(8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_now("memwr_locked", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    idle();
    tick(3);

`ifdef CPC_MULTIROM_PROG_EN
    io_write(8'hFE, 8'hA5);
    io_write(8'hFE, 8'h5A);
    bus(8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_now("memwr_unlocked", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    tick(2);
    idle();
    busy_cycles = 0;
    tick(5);
    bus(8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_now("memwr_during_busy", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1);
    tick(2);
    idle();
    tick(15);
    chk_int("busy_cycles", busy_cycles, 8);
    expect_now("after_recover", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);

    pulse_reset();
    io_write(8'hFE, 8'hA5);
    io_write(8'hFE, 8'h33);
    bus(8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_now("bad_key_locked", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    idle();
    tick(3);
    io_write(8'hFE, 8'h5A);
    bus(8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_now("key2_alone_locked", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    idle();
    tick(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpc_multirom_ctrl.md
Name: cpc_multirom_ctrl

Overview:
CPLD-resident controller for an N-socket CPC upper-ROM expansion. It is the parametrised successor of the fixed four-ROM CPLD decode. It latches the upper ROM number from CPC I/O writes to &DFxx and maps it onto any number of 28C256-class sockets, each holding several 16K banks. It drives per-socket chip selects, the shared OE and bank address, and ROMDIS, with per-bank DIP enables. It also provides an unlock-gated in-system EEPROM write path.

Parameters:
NUM_SKT, 2, number of ROM sockets (1..8)
BANKS_PER_SKT, 2, 16K banks per socket (power of 2, 1..4)
ROM_BASE, 0, first upper ROM number served (0..255-NUM_SKT*BANKS_PER_SKT+1)
SYNC_STAGES, 2, synchroniser depth for IOREQ_B/MREQ_B/WR_B (>=2)
PROG_PORT, 8'hFE, A15..A8 value of the programming key port (must have bit5=1)
WR_RECOVER, 40000, CLK cycles of write-recovery lockout (10 ms at 4 MHz)

Ports:
CLK  in  1  CPC 4 MHz bus clock
RESET  in  1  asynchronous, active-high reset
A_HI  in  8  A15..A8
D  in  8  data bus
MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B  in  1 each  CPC bus strobes, active low
dip  in  NUM_SKT*BANKS_PER_SKT  per-bank enable, 1 = bank serves its ROM number
rom_cs_b  out  NUM_SKT  per-socket chip select, active low
roma_hi  out  max(1,log2 BANKS_PER_SKT)  bank address within socket (A14 upward)
romoe_b  out  1  shared output enable, active low
romdis  out  1  to ROMDIS via diode, active high
rom_we_b  out  NUM_SKT  per-socket write enable, active low
rom_sel  out  8  latched upper ROM number
prog_busy  out  1  write-recovery in progress

Behaviour:
- Reset values: rom_sel=0, rom_cs_b all 1, romoe_b=1, romdis=0, rom_we_b all 1, prog_busy=0, key FSM=LOCKED.
- IOREQ_B, MREQ_B and WR_B pass through SYNC_STAGES flops. A ROM-select write is the first cycle in which synced IOREQ_B=0 and synced WR_B=0 with A13=0, after both were high in the previous synced cycle. On that cycle D is captured into rom_sel. rom_sel updates SYNC_STAGES+1 cycles after the strobes fall. Only one capture occurs per strobe assertion.
- Index idx = rom_sel-ROM_BASE. hit = (rom_sel in [ROM_BASE, ROM_BASE+N)) & dip[idx], registered one cycle after rom_sel changes. socket = idx/BANKS_PER_SKT. roma_hi = idx%BANKS_PER_SKT, registered.
- Upper access: ROMEN_B=0 & A15=1 & A14=1. The following are combinational from the bus with registered hit:
  - romdis = hit & upper.
  - romoe_b = ~(hit & upper & ~RD_B).
  - rom_cs_b[socket] = ~(hit & upper); all other bits are 1.
- hit=0 (out of range, or DIP off): all outputs are inactive and the internal/other ROM answers.
- Rewriting rom_sel to the same value re-latches it with no glitch. Reset during any strobe aborts the capture.

Optional Feature:
Macro CPC_MULTIROM_PROG_EN.
- Defined: key FSM with states LOCKED, KEY1, UNLOCKED, RECOVER, driven by synced I/O writes to A_HI==PROG_PORT.
  - LOCKED: write A5 -> KEY1. Any other value stays LOCKED.
  - KEY1: write 5A -> UNLOCKED. Any other value -> LOCKED.
  - UNLOCKED: rom_we_b[socket] = ~(hit & ~MREQ_B & ~WR_B & A15 & A14), combinational. ROMEN_B is ignored. A synced WR_B rising edge ending such a write -> RECOVER, load counter with WR_RECOVER-1. Any PROG_PORT write -> LOCKED.
  - RECOVER: prog_busy=1 and rom_we_b is held all 1. The counter decrements each cycle; at 0 -> UNLOCKED. A PROG_PORT write -> LOCKED after the count completes.
- Not defined: FSM and counter are absent. rom_we_b is tied all 1 and prog_busy is tied 0.

Decomposition:
Package cpc_multirom_pkg holds:
- key constants KEY1_VAL=8'hA5 and KEY2_VAL=8'h5A;
- the key FSM state enum;
- a clog2 function;
- the upper-area and ROM-select-port decode constants.

One sub-module, cpc_bus_sync: a SYNC_STAGES synchroniser for the strobes, with falling/rising edge-detect outputs.

Test Plan:
- Reset, then I/O write D=&01 to &DF00 with dip=4'b1111 → rom_sel=&01 after 3 CLK. Read at &C000 with ROMEN_B=0 → rom_cs_b=2'b10, roma_hi=1, romoe_b=0, romdis=1.
- Select ROM &03 with dip[3]=0 → upper read gives romdis=0, rom_cs_b=2'b11, romoe_b=1.
- Select ROM &07 (out of range, ROM_BASE=0, N=4) → all outputs inactive. Select &02 → rom_cs_b=2'b01, roma_hi=0.
- I/O write to &FF00 (A13=1) with D=&02 → rom_sel unchanged. Assert RESET mid-strobe → rom_sel=0 and outputs inactive.
- PROG_EN, WR_RECOVER=8: write A5 then 5A to &FE00, then memory write to &C000 with rom_sel=&00 → rom_we_b=2'b10 while WR_B=0, then prog_busy=1 for 8 cycles. A second write during busy → rom_we_b stays 2'b11.
- PROG_EN: write A5 then 33 to &FE00, then memory write to &C000 → rom_we_b stays 2'b11, FSM=LOCKED.
